// File: rtl/trng_word_ctrl.sv
// Word-collection sequencer for the TRNG shift register: clear, count WIDTH bits, capture, present.
// Optional stuck-word rejection is enabled by defining TRNG_STUCK_WORD_DETECT_EN.
module trng_word_ctrl #(
    parameter int WIDTH = 32,
    parameter int OVR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             bit_valid,
    input  logic [WIDTH-1:0] sr_word,
    output logic             sr_load,
    output logic             sr_clr,
    output logic             sr_bit_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
`ifdef TRNG_STUCK_WORD_DETECT_EN
    output logic             stuck_flag,
`endif
    output logic [OVR_W-1:0] overrun_cnt
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [OVR_W-1:0] OVR_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COLLECT,
        S_CAPTURE,
        S_PRESENT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic             collect_q;

`ifdef TRNG_STUCK_WORD_DETECT_EN
    logic [WIDTH-1:0] last_word;
    logic             have_last;
    logic             reject;

    always_comb begin
        reject = (sr_word == '0) || (sr_word == '1) ||
                 (have_last && (sr_word == last_word));
    end
`endif

    // The shift strobe must reach the register in the same cycle as the bit.
    assign sr_bit_valid = collect_q & bit_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            collect_q   <= 1'b0;
            sr_load     <= 1'b0;
            sr_clr      <= 1'b0;
            busy        <= 1'b0;
            word_out    <= '0;
            word_valid  <= 1'b0;
            overrun_cnt <= '0;
`ifdef TRNG_STUCK_WORD_DETECT_EN
            stuck_flag  <= 1'b0;
            last_word   <= '0;
            have_last   <= 1'b0;
`endif
        end else begin
            if ((state == S_CAPTURE || state == S_PRESENT) && bit_valid &&
                overrun_cnt != OVR_MAX) begin
                overrun_cnt <= overrun_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state   <= S_CLEAR;
                        sr_load <= 1'b1;
                        sr_clr  <= 1'b1;
                        busy    <= 1'b1;
                    end
                end

                S_CLEAR: begin
                    bit_cnt   <= '0;
                    sr_clr    <= 1'b0;
                    collect_q <= 1'b1;
                    state     <= S_COLLECT;
                end

                S_COLLECT: begin
                    // Disable wins over a final bit arriving in the same cycle.
                    if (!enable) begin
                        state     <= S_IDLE;
                        collect_q <= 1'b0;
                        sr_load   <= 1'b0;
                        busy      <= 1'b0;
                    end else if (bit_valid) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state     <= S_CAPTURE;
                            collect_q <= 1'b0;
                        end
                    end
                end

                S_CAPTURE: begin
`ifdef TRNG_STUCK_WORD_DETECT_EN
                    if (reject) begin
                        stuck_flag <= 1'b1;
                        sr_clr     <= 1'b1;
                        state      <= S_CLEAR;
                    end else begin
                        word_out   <= sr_word;
                        word_valid <= 1'b1;
                        last_word  <= sr_word;
                        have_last  <= 1'b1;
                        state      <= S_PRESENT;
                    end
`else
                    word_out   <= sr_word;
                    word_valid <= 1'b1;
                    state      <= S_PRESENT;
`endif
                end

                S_PRESENT: begin
                    if (word_valid && word_ready) begin
                        word_valid <= 1'b0;
                        if (enable) begin
                            sr_clr <= 1'b1;
                            state  <= S_CLEAR;
                        end else begin
                            sr_load <= 1'b0;
                            busy    <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    collect_q <= 1'b0;
                    sr_load   <= 1'b0;
                    sr_clr    <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trng_word_ctrl.sv
// Scoreboard bench for trng_word_ctrl with a behavioural model of the external shift register.
module tb_trng_word_ctrl;

    logic        clk = 1'b0;
    logic        rst, enable, bit_valid, word_ready, din;
    logic [31:0] sr_word = '0;
    logic        sr_load, sr_clr, sr_bit_valid, word_valid, busy;
    logic [31:0] word_out;
    logic [7:0]  overrun_cnt;
`ifdef TRNG_STUCK_WORD_DETECT_EN
    logic        stuck_flag;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] exp_q[$];

    trng_word_ctrl #(.WIDTH(32), .OVR_W(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .bit_valid(bit_valid),
        .sr_word(sr_word), .sr_load(sr_load), .sr_clr(sr_clr),
        .sr_bit_valid(sr_bit_valid), .word_out(word_out), .word_valid(word_valid),
        .word_ready(word_ready), .busy(busy),
`ifdef TRNG_STUCK_WORD_DETECT_EN
        .stuck_flag(stuck_flag),
`endif
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    // External shift register: MSB-first shift-left collection.
    always @(posedge clk) begin
        if (sr_load) begin
            if (sr_clr) sr_word <= '0;
            else if (sr_bit_valid) sr_word <= {sr_word[30:0], din};
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: pops the expected word on each handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (sr_bit_valid)
                check("strobe_gating", {61'd0, sr_load, sr_clr, word_valid}, 64'b100);
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_word: got %0h expected none at %0t", word_out, $time);
                end else begin
                    check("word_out", {32'd0, word_out}, {32'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        din       = b;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] w, input int n, input int gap_pct);
        for (int i = 31; i > 31 - n; i--) begin
            for (int g = 0; g < 20 && $urandom_range(0, 99) < gap_pct; g++) tick();
            send_bit(w[i]);
        end
    endtask

    task automatic wait_clr();
        int n = 0;
        while (!sr_clr && n < 20) begin
            tick();
            n++;
        end
        check("clr_seen", {63'd0, sr_clr}, 64'd1);
        tick();
    endtask

    // Drop back to IDLE, then re-enable and land at the first COLLECT cycle.
    task automatic restart();
        int n = 0;
        enable = 1'b0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("idle_reached", {63'd0, busy}, 64'd0);
        enable = 1'b1;
        wait_clr();
    endtask

    initial begin
        logic [31:0] w;
        int clr_cnt;
        int bad;
        int n;

        rst = 1'b1; enable = 1'b0; bit_valid = 1'b0; word_ready = 1'b0; din = 1'b0;
        repeat (3) tick();
        check("reset_ctrl", {59'd0, sr_load, sr_clr, sr_bit_valid, word_valid, busy}, 64'd0);
        check("reset_word", {32'd0, word_out}, 64'd0);
        check("reset_ovr", {56'd0, overrun_cnt}, 64'd0);
`ifdef TRNG_STUCK_WORD_DETECT_EN
        check("reset_stuck", {63'd0, stuck_flag}, 64'd0);
`endif
        rst = 1'b0;
        tick();

        // Reset in the middle of collection.
        enable = 1'b1;
        wait_clr();
        send_bits(32'hFFC0_0000, 10, 0);
        rst = 1'b1;
        tick();
        check("midrst_ctrl", {59'd0, sr_load, sr_clr, sr_bit_valid, word_valid, busy}, 64'd0);
        rst = 1'b0;
        clr_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            clr_cnt += int'(sr_clr);
        end
        check("restart_clr_pulses", 64'(clr_cnt), 64'd1);
        check("restart_busy", {63'd0, busy}, 64'd1);

        // Basic word with latency and single-cycle valid.
        word_ready = 1'b1;
        send_bits(32'hA5A5_3C3C, 32, 0);
        exp_q.push_back(32'hA5A5_3C3C);
        check("latency_capture", {63'd0, word_valid}, 64'd0);
        tick();
        check("latency_present", {63'd0, word_valid}, 64'd1);
        check("basic_word", {32'd0, word_out}, {32'd0, 32'hA5A5_3C3C});
        tick();
        check("valid_one_cycle", {63'd0, word_valid}, 64'd0);

        // Back-pressure with continuous bits, overrun saturates.
        w = 32'h5EED_1234;
        word_ready = 1'b0;
        restart();
        send_bits(w, 31, 0);
        bit_valid = 1'b1;
        din = w[0];
        tick();
        exp_q.push_back(w);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i > 0 && word_out !== w) bad++;
        end
        bit_valid = 1'b0;
        check("bp_stable", 64'(bad), 64'd0);
        check("bp_valid", {63'd0, word_valid}, 64'd1);
        check("bp_word", {32'd0, word_out}, {32'd0, w});
        check("ovr_saturated", {56'd0, overrun_cnt}, 64'd255);
        word_ready = 1'b1;
        wait_clr();
        send_bits(32'h0F0F_F0F0, 32, 0);
        exp_q.push_back(32'h0F0F_F0F0);
        repeat (3) tick();
        check("ovr_held", {56'd0, overrun_cnt}, 64'd255);

        // Disable after 17 bits discards the partial word.
        restart();
        send_bits(32'hDEAD_BEEF, 17, 0);
        enable = 1'b0;
        tick();
        check("disable_idle", {63'd0, busy}, 64'd0);
        repeat (3) tick();
        check("disable_no_word", {63'd0, word_valid}, 64'd0);

        // Disable beats a final bit in the same cycle.
        restart();
        send_bits(32'h1357_9BDF, 31, 0);
        bit_valid = 1'b1;
        din = 1'b1;
        enable = 1'b0;
        tick();
        bit_valid = 1'b0;
        check("final_bit_disable_idle", {63'd0, busy}, 64'd0);
        repeat (3) tick();
        check("final_bit_no_word", {63'd0, word_valid}, 64'd0);

        // Disable during PRESENT keeps the word until accepted.
        word_ready = 1'b0;
        restart();
        send_bits(32'hC001_D00D, 32, 0);
        exp_q.push_back(32'hC001_D00D);
        tick();
        enable = 1'b0;
        repeat (3) tick();
        check("present_hold_valid", {63'd0, word_valid}, 64'd1);
        check("present_hold_busy", {63'd0, busy}, 64'd1);
        check("present_hold_word", {32'd0, word_out}, {32'd0, 32'hC001_D00D});
        word_ready = 1'b1;
        tick();
        check("present_release", {62'd0, busy, word_valid}, 64'd0);

        // Gapped bit arrival.
        restart();
        send_bits(32'h9E37_79B9, 32, 70);
        exp_q.push_back(32'h9E37_79B9);
        check("gap_capture", {63'd0, word_valid}, 64'd0);
        tick();
        check("gap_present", {63'd0, word_valid}, 64'd1);
        wait_clr();
        send_bits(32'h0000_0001, 32, 30);
        exp_q.push_back(32'h0000_0001);
        tick();
        check("gap2_present", {63'd0, word_valid}, 64'd1);

`ifdef TRNG_STUCK_WORD_DETECT_EN
        restart();
        send_bits(32'h0000_0000, 32, 0);
        tick();
        check("stuck_zero_reject", {63'd0, word_valid}, 64'd0);
        check("stuck_flag_set", {63'd0, stuck_flag}, 64'd1);
        wait_clr();
        send_bits(32'h1234_5678, 32, 0);
        exp_q.push_back(32'h1234_5678);
        tick();
        check("stuck_first_ok", {63'd0, word_valid}, 64'd1);
        wait_clr();
        send_bits(32'h1234_5678, 32, 0);
        tick();
        check("stuck_repeat_reject", {63'd0, word_valid}, 64'd0);
`endif

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check("queue_drain", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
